corr_acc_sched: RTL and testbench

- Sequencer that drives the correlation-matrix accelerator through its 32-bit memory-split slave port.
- Accepts packed samples from a valid/ready stream and writes each one to the accelerator sample-FIFO address only while the accelerator acknowledges.
- After a programmed number of samples it reads every accumulated matrix word and emits the words on a result stream, then pulses done.
- Sits between the tile's DMA/sample source and the accelerator, replacing CPU-driven polling.

---
 rtl/corr_acc_pkg.sv | 35 +++
 rtl/corr_res_skid.sv | 33 +++
 rtl/corr_acc_sched.sv | 201 ++++++++++++++++++++
 tb/tb_corr_acc_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_acc_pkg.sv
// Shared types and constants for the correlation-accelerator sequencer.
// Holds the FSM state enum, default address map, result geometry and word-address helpers.
package corr_acc_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StFeed,
      StDrain,
      StRead,
      StDone
   } state_e;

   localparam logic [31:0] CORR_MATRIX_BASE = 32'h80000080;
   localparam logic [31:0] CORR_FIFO_BASE   = 32'h80000040;
   localparam int unsigned CORR_RES_DEPTH   = 12;
   localparam int unsigned CORR_RES_BANKS   = 2;

   // Each bank entry holds a real/imag word pair.
   function automatic int unsigned res_words(input int unsigned depth, input int unsigned banks);
      return depth * banks * 2;
   endfunction

   // Word index bits map to {entry, bank, imag}.
   function automatic logic [31:0] res_addr(input logic [31:0] base, input logic [29:0] w);
      logic [27:0] entry;
      logic        bank;
      logic        imag;
      imag  = w[0];
      bank  = w[1];
      entry = w[29:2];
      return base + {entry, bank, imag, 2'b00};
   endfunction

endpackage

// File: rtl/corr_res_skid.sv
// One-entry result holding register with valid/ready handshake.
// Loads on i_valid and holds until the consumer accepts it.
module corr_res_skid #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_valid) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/corr_acc_sched.sv
// Feeds packed samples into the correlation accelerator, then reads the matrix out as a stream.
// Defining CORR_ACC_SCHED_PERF_EN adds the stall_cnt_o ack-stall counter.
module corr_acc_sched
   import corr_acc_pkg::*;
#(
   parameter logic [31:0] MATRIX_BASE_ADDR = CORR_MATRIX_BASE,
   parameter logic [31:0] FIFO_BASE_ADDR   = CORR_FIFO_BASE,
   parameter int unsigned RES_DEPTH        = CORR_RES_DEPTH,
   parameter int unsigned RES_BANKS        = CORR_RES_BANKS,
   parameter int unsigned CNT_W            = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [CNT_W-1:0] nsmpl_i,
   input  logic             smpl_valid_i,
   input  logic [31:0]      smpl_data_i,
   output logic             smpl_ready_o,
   output logic             acc_req_o,
   output logic             acc_we_o,
   output logic [31:0]      acc_addr_o,
   output logic [31:0]      acc_wdata_o,
   input  logic             acc_ack_i,
   input  logic             acc_resp_i,
   input  logic [31:0]      acc_rdata_i,
   output logic             acc_on_o,
   output logic             res_valid_o,
   output logic [31:0]      res_data_o,
   input  logic             res_ready_i,
   output logic             busy_o,
   output logic             done_o
`ifdef CORR_ACC_SCHED_PERF_EN
   ,
   output logic [31:0]      stall_cnt_o
`endif
);

   localparam int unsigned      WORDS   = res_words(RES_DEPTH, RES_BANKS);
   localparam int unsigned      IDX_W   = $clog2(WORDS + 1);
   localparam logic [IDX_W-1:0] WORDS_L = IDX_W'(WORDS);
   localparam logic [IDX_W-1:0] LAST_L  = IDX_W'(WORDS - 1);

   state_e           r_state;
   logic [CNT_W-1:0] r_nsmpl;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_rd_idx;
   logic [IDX_W-1:0] r_acc_cnt;
   logic             r_rd_pend;
   logic             r_ack_seen;
   logic             r_acc_on;
   logic             r_busy;
   logic             r_done;

   logic             w_wr;
   logic             w_rd_want;
   logic             w_rd;
   logic             w_resp;
   logic             w_res_valid;
   logic             w_res_acc;
   logic [31:0]      w_res_data;

   assign w_wr      = (r_state == StFeed) & acc_ack_i & smpl_valid_i;
   // Only one read in flight, and never while the holding register is occupied.
   assign w_rd_want = (r_state == StRead) & ~w_res_valid & ~r_rd_pend & (r_rd_idx < WORDS_L);
   assign w_rd      = w_rd_want & acc_ack_i;
   assign w_resp    = r_rd_pend & acc_resp_i;
   assign w_res_acc = w_res_valid & res_ready_i;

   assign acc_req_o    = w_wr | w_rd;
   assign acc_we_o     = w_wr;
   assign smpl_ready_o = w_wr;
   assign acc_wdata_o  = w_wr ? smpl_data_i : 32'h0;

   always_comb begin
      acc_addr_o = 32'h0;
      if (w_wr) begin
         acc_addr_o = FIFO_BASE_ADDR;
      end else if (w_rd) begin
         acc_addr_o = res_addr(MATRIX_BASE_ADDR, 30'(r_rd_idx));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_nsmpl    <= '0;
         r_cnt      <= '0;
         r_rd_idx   <= '0;
         r_acc_cnt  <= '0;
         r_rd_pend  <= 1'b0;
         r_ack_seen <= 1'b0;
         r_acc_on   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_rd) begin
            r_rd_pend <= 1'b1;
            r_rd_idx  <= r_rd_idx + 1'b1;
         end else if (w_resp) begin
            r_rd_pend <= 1'b0;
         end
         unique case (r_state)
            StIdle: begin
               if (start_i) begin
                  r_state   <= StArm;
                  r_nsmpl   <= nsmpl_i;
                  r_cnt     <= '0;
                  r_rd_idx  <= '0;
                  r_acc_cnt <= '0;
                  r_acc_on  <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            StArm: begin
               if (r_nsmpl == '0) begin
                  r_state  <= StRead;
                  r_acc_on <= 1'b0;
               end else begin
                  r_state <= StFeed;
               end
            end
            StFeed: begin
               if (w_wr) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt + 1'b1 == r_nsmpl) begin
                     r_state    <= StDrain;
                     r_ack_seen <= 1'b0;
                  end
               end
            end
            StDrain: begin
               // Two consecutive acks mean the accelerator pipeline has flushed.
               if (acc_ack_i) begin
                  if (r_ack_seen) begin
                     r_state  <= StRead;
                     r_acc_on <= 1'b0;
                  end else begin
                     r_ack_seen <= 1'b1;
                  end
               end else begin
                  r_ack_seen <= 1'b0;
               end
            end
            StRead: begin
               if (w_res_acc) begin
                  if (r_acc_cnt == LAST_L) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end else begin
                     r_acc_cnt <= r_acc_cnt + 1'b1;
                  end
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   corr_res_skid #(
      .DATA_W(32)
   ) u_res_skid (
      .clk    (clk),
      .rst    (rst),
      .i_valid(w_resp),
      .i_data (acc_rdata_i),
      .i_ready(res_ready_i),
      .o_valid(w_res_valid),
      .o_data (w_res_data)
   );

   assign res_valid_o = w_res_valid;
   assign res_data_o  = w_res_data;
   assign acc_on_o    = r_acc_on;
   assign busy_o      = r_busy;
   assign done_o      = r_done;

`ifdef CORR_ACC_SCHED_PERF_EN
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = (((r_state == StFeed) & smpl_valid_i) | w_rd_want) & ~acc_ack_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if ((r_state == StIdle) && start_i) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_corr_acc_sched.sv
// Directed bench for corr_acc_sched with a small accelerator response model.
module tb_corr_acc_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [15:0] nsmpl_i;
   logic        smpl_valid_i;
   logic [31:0] smpl_data_i;
   logic        smpl_ready_o;
   logic        acc_req_o;
   logic        acc_we_o;
   logic [31:0] acc_addr_o;
   logic [31:0] acc_wdata_o;
   logic        acc_ack_i;
   logic        acc_resp_i;
   logic [31:0] acc_rdata_i;
   logic        acc_on_o;
   logic        res_valid_o;
   logic [31:0] res_data_o;
   logic        res_ready_i;
   logic        busy_o;
   logic        done_o;
`ifdef CORR_ACC_SCHED_PERF_EN
   logic [31:0] stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n, wr_n, rd_n, res_n, done_n, smpl_idx;
   int bad_req, bad_rdy, bad_on, bad_rd;
   int ack_mode, vld_mode;
   logic        resp_nxt;
   logic [31:0] resp_addr;
   logic [31:0] wr_addr [0:63];
   logic [31:0] wr_data [0:63];
   int          wr_cyc  [0:63];
   logic [31:0] rd_addr [0:63];
   int          rd_cyc  [0:63];
   logic [31:0] res_log [0:63];

   corr_acc_sched dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .nsmpl_i     (nsmpl_i),
      .smpl_valid_i(smpl_valid_i),
      .smpl_data_i (smpl_data_i),
      .smpl_ready_o(smpl_ready_o),
      .acc_req_o   (acc_req_o),
      .acc_we_o    (acc_we_o),
      .acc_addr_o  (acc_addr_o),
      .acc_wdata_o (acc_wdata_o),
      .acc_ack_i   (acc_ack_i),
      .acc_resp_i  (acc_resp_i),
      .acc_rdata_i (acc_rdata_i),
      .acc_on_o    (acc_on_o),
      .res_valid_o (res_valid_o),
      .res_data_o  (res_data_o),
      .res_ready_i (res_ready_i),
      .busy_o      (busy_o),
`ifdef CORR_ACC_SCHED_PERF_EN
      .stall_cnt_o (stall_cnt),
`endif
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] sample(input int k);
      logic [7:0] b;
      b = 8'(4 * k + 1);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   function automatic logic [31:0] exp_word(input int i);
      return 32'hC0DE0080 + 32'(i * 4);
   endfunction

   task automatic reset_logs();
      wr_n = 0; rd_n = 0; res_n = 0; done_n = 0; smpl_idx = 0;
      bad_req = 0; bad_rdy = 0; bad_on = 0; bad_rd = 0;
   endtask

   // Observe at negedge, then advance to just after the next posedge and drive the model.
   task automatic tick();
      @(negedge clk);
      if (acc_req_o && !acc_ack_i) bad_req++;
      if (smpl_ready_o && !acc_ack_i) bad_rdy++;
      if (acc_req_o && acc_we_o) begin
         if (wr_n < 64) begin
            wr_addr[wr_n] = acc_addr_o; wr_data[wr_n] = acc_wdata_o; wr_cyc[wr_n] = cyc_n;
         end
         if (!acc_on_o) bad_on++;
         wr_n++; smpl_idx++;
      end
      if (acc_req_o && !acc_we_o && acc_ack_i) begin
         if (rd_n < 64) begin
            rd_addr[rd_n] = acc_addr_o; rd_cyc[rd_n] = cyc_n;
         end
         if (acc_on_o) bad_on++;
         if (res_valid_o) bad_rd++;
         rd_n++; resp_nxt = 1'b1; resp_addr = acc_addr_o;
      end
      if (res_valid_o && res_ready_i) begin
         if (res_n < 64) res_log[res_n] = res_data_o;
         res_n++;
      end
      if (done_o) done_n++;
      @(posedge clk); #1;
      cyc_n++;
      acc_resp_i   = resp_nxt;
      acc_rdata_i  = resp_nxt ? {16'hC0DE, resp_addr[15:0]} : 32'h0;
      resp_nxt     = 1'b0;
      acc_ack_i    = (ack_mode == 0) ? 1'b1 : cyc_n[0];
      smpl_valid_i = (vld_mode == 0) ? 1'b1 : (cyc_n % 3 == 0);
      smpl_data_i  = sample(smpl_idx);
   endtask

   task automatic pulse_start(input logic [15:0] n);
      start_i = 1'b1; nsmpl_i = n;
      tick();
      start_i = 1'b0;
   endtask

   task automatic run_to_done();
      for (int g = 0; g < 600 && done_n == 0; g++) tick();
   endtask

   task automatic check_readout(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < 48; i++) begin
         if (rd_addr[i] !== 32'h80000080 + 32'(i * 4)) bad++;
         if (res_log[i] !== exp_word(i)) bad++;
      end
      n_tests++;
      if (rd_n != 48 || res_n != 48 || bad != 0) begin
         n_fail++;
         $display("FAIL %s_readout: reads %0d results %0d bad %0d, want 48 48 0", tag, rd_n, res_n, bad);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start_i = 1'b0; nsmpl_i = '0; smpl_valid_i = 1'b0; smpl_data_i = '0;
      acc_ack_i = 1'b0; acc_resp_i = 1'b0; acc_rdata_i = '0; res_ready_i = 1'b1;
      resp_nxt = 1'b0; resp_addr = '0; ack_mode = 0; vld_mode = 0; cyc_n = 0;
      reset_logs();
      #1 rst = 1'b1;
      #2;
      n_tests++;
      if ({acc_req_o, acc_we_o, smpl_ready_o, acc_on_o, res_valid_o, busy_o, done_o} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {acc_req_o, acc_we_o, smpl_ready_o, acc_on_o, res_valid_o, busy_o, done_o});
      end
      n_tests++;
      if (acc_addr_o !== 32'h0 || acc_wdata_o !== 32'h0 || res_data_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: addr %h wdata %h res %h want 0", acc_addr_o, acc_wdata_o, res_data_o);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int st;
      reset_logs(); ack_mode = 0; vld_mode = 0; res_ready_i = 1'b1;
      st = cyc_n;
      pulse_start(16'd4);
      run_to_done();
      n_tests++;
      if (wr_n != 4) begin n_fail++; $display("FAIL basic_wr_n: got %0d want 4", wr_n); end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (wr_addr[i] !== 32'h80000040 || wr_data[i] !== sample(i)) begin
            n_fail++;
            $display("FAIL basic_wr%0d: addr %h data %h want 80000040 %h", i, wr_addr[i], wr_data[i], sample(i));
         end
      end
      n_tests++;
      if (wr_cyc[3] - wr_cyc[0] != 3 || wr_cyc[0] - st < 2) begin
         n_fail++;
         $display("FAIL basic_wr_timing: first %0d last %0d start %0d", wr_cyc[0], wr_cyc[3], st);
      end
      n_tests++;
      if (rd_addr[0] !== 32'h80000080 || rd_addr[1] !== 32'h80000084 || rd_addr[4] !== 32'h80000090) begin
         n_fail++;
         $display("FAIL basic_rd_addr: got %h %h %h want 80000080 80000084 80000090",
                  rd_addr[0], rd_addr[1], rd_addr[4]);
      end
      check_readout("basic");
      n_tests++;
      if (rd_cyc[47] - rd_cyc[0] > 141) begin
         n_fail++;
         $display("FAIL basic_rd_rate: span %0d want <= 141", rd_cyc[47] - rd_cyc[0]);
      end
      n_tests++;
      if (bad_on != 0) begin n_fail++; $display("FAIL basic_acc_on: bad %0d want 0", bad_on); end
      n_tests++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy_o); end
      repeat (3) tick();
      n_tests++;
      if (done_n != 1) begin n_fail++; $display("FAIL basic_done: pulses %0d want 1", done_n); end
   endtask

   task automatic test_ack_toggle();
      reset_logs(); ack_mode = 1; vld_mode = 0;
      pulse_start(16'd3);
      for (int g = 0; g < 50 && wr_n < 3; g++) tick();
      ack_mode = 0;
      run_to_done();
      n_tests++;
      if (wr_n != 3) begin n_fail++; $display("FAIL ackt_wr_n: got %0d want 3", wr_n); end
      n_tests++;
      if (bad_req != 0 || bad_rdy != 0) begin
         n_fail++;
         $display("FAIL ackt_no_ack: req %0d ready %0d want 0 0", bad_req, bad_rdy);
      end
      n_tests++;
      if (wr_data[2] !== sample(2)) begin
         n_fail++; $display("FAIL ackt_data: got %h want %h", wr_data[2], sample(2));
      end
      n_tests++;
      if (done_n != 1) begin n_fail++; $display("FAIL ackt_done: pulses %0d want 1", done_n); end
   endtask

   task automatic test_valid_gaps();
      reset_logs(); ack_mode = 0; vld_mode = 1;
      pulse_start(16'd3);
      for (int g = 0; g < 50 && wr_n < 2; g++) tick();
      tick();
      n_tests++;
      if (wr_n != 2 || acc_on_o !== 1'b1 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL gaps_hold: wr %0d on %b busy %b want 2 1 1", wr_n, acc_on_o, busy_o);
      end
      run_to_done();
      vld_mode = 0;
      n_tests++;
      if (wr_n != 3 || wr_cyc[1] - wr_cyc[0] != 3 || wr_data[2] !== sample(2)) begin
         n_fail++;
         $display("FAIL gaps_writes: n %0d gap %0d data %h want 3 3 %h",
                  wr_n, wr_cyc[1] - wr_cyc[0], wr_data[2], sample(2));
      end
      n_tests++;
      if (rd_cyc[0] <= wr_cyc[2]) begin
         n_fail++; $display("FAIL gaps_order: first read %0d last write %0d", rd_cyc[0], wr_cyc[2]);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] hold;
      int hold_rd, bad;
      reset_logs(); ack_mode = 0; vld_mode = 0;
      pulse_start(16'd0);
      for (int g = 0; g < 100 && res_n < 5; g++) tick();
      res_ready_i = 1'b0;
      for (int g = 0; g < 8 && !res_valid_o; g++) tick();
      hold = res_data_o; hold_rd = rd_n; bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (res_valid_o !== 1'b1 || res_data_o !== hold) bad++;
      end
      n_tests++;
      if (hold !== exp_word(5)) begin
         n_fail++; $display("FAIL bp_word: got %h want %h", hold, exp_word(5));
      end
      n_tests++;
      if (bad != 0 || rd_n != hold_rd || bad_rd != 0) begin
         n_fail++;
         $display("FAIL bp_stable: unstable %0d reads %0d->%0d overlap %0d", bad, hold_rd, rd_n, bad_rd);
      end
      res_ready_i = 1'b1;
      run_to_done();
      check_readout("bp");
   endtask

   task automatic test_back_to_back();
      reset_logs(); ack_mode = 0; vld_mode = 0;
      pulse_start(16'd5);
      for (int g = 0; g < 50 && wr_n < 2; g++) tick();
      pulse_start(16'd1);
      run_to_done();
      n_tests++;
      if (wr_n != 5 || done_n != 1) begin
         n_fail++; $display("FAIL b2b_ignore: wr %0d done %0d want 5 1", wr_n, done_n);
      end
      reset_logs();
      pulse_start(16'd2);
      run_to_done();
      n_tests++;
      if (wr_n != 2 || wr_data[1] !== sample(1) || done_n != 1) begin
         n_fail++; $display("FAIL b2b_fresh: wr %0d data %h done %0d want 2 %h 1", wr_n, wr_data[1], done_n, sample(1));
      end
      reset_logs();
      pulse_start(16'd0);
      run_to_done();
      n_tests++;
      if (wr_n != 0 || done_n != 1) begin
         n_fail++; $display("FAIL b2b_zero: wr %0d done %0d want 0 1", wr_n, done_n);
      end
      check_readout("zero");
   endtask

   task automatic test_reset_mid();
      reset_logs(); ack_mode = 0; vld_mode = 0;
      pulse_start(16'd0);
      for (int g = 0; g < 200 && rd_n < 21; g++) tick();
      tick();
      n_tests++;
      if (busy_o !== 1'b1 || res_valid_o !== 1'b1 || rd_addr[20] !== 32'h800000D0) begin
         n_fail++;
         $display("FAIL rstmid_pre: busy %b valid %b addr %h want 1 1 800000d0", busy_o, res_valid_o, rd_addr[20]);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({acc_req_o, acc_on_o, res_valid_o, busy_o, done_o, smpl_ready_o} !== 6'b0 ||
          acc_addr_o !== 32'h0 || res_data_o !== 32'h0) begin
         n_fail++;
         $display("FAIL rstmid_zero: ctrl %b addr %h res %h want 0",
                  {acc_req_o, acc_on_o, res_valid_o, busy_o, done_o, smpl_ready_o}, acc_addr_o, res_data_o);
      end
      repeat (2) tick();
      rst = 1'b0;
      reset_logs();
      repeat (3) tick();
      n_tests++;
      if (busy_o !== 1'b0 || rd_n != 0) begin
         n_fail++; $display("FAIL rstmid_idle: busy %b reads %0d want 0 0", busy_o, rd_n);
      end
      pulse_start(16'd1);
      run_to_done();
      n_tests++;
      if (wr_n != 1 || done_n != 1) begin
         n_fail++; $display("FAIL rstmid_rerun: wr %0d done %0d want 1 1", wr_n, done_n);
      end
      check_readout("rerun");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ack_toggle();
      test_valid_gaps();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
